pattern_fsm_bank: RTL and testbench

PATTERN_FSM_BANK -- requirements
Module: pattern_fsm_bank

---
 rtl/pattern_fsm_pkg.sv | 37 +++
 rtl/pattern_fsm_ch.sv | 80 ++++++++
 rtl/pattern_fsm_bank.sv | 38 +++
 tb/tb_pattern_fsm_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pattern_fsm_pkg.sv
// Shared state encoding and next-state rule for the pattern FSM bank.
// Optional hit counters are enabled by the PATTERN_FSM_HIT_CNT_EN macro.
package pattern_fsm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_0 = 3'b000;
    localparam state_t ST_1 = 3'b001;
    localparam state_t ST_2 = 3'b010;
    localparam state_t ST_3 = 3'b011;
    localparam state_t ST_4 = 3'b100;

    function automatic logic state_illegal(input state_t s);
        return (s > ST_4);
    endfunction

    // Illegal codes recover to ST_0 even when the channel is not enabled.
    function automatic state_t fsm_next(input state_t s, input logic adv, input logic x);
        state_t n;
        if (state_illegal(s)) begin
            n = ST_0;
        end else if (!adv) begin
            n = s;
        end else begin
            case (s)
                ST_0:    n = x ? ST_1 : ST_0;
                ST_1:    n = x ? ST_4 : ST_1;
                ST_2:    n = x ? ST_1 : ST_2;
                ST_3:    n = x ? ST_2 : ST_1;
                ST_4:    n = x ? ST_4 : ST_3;
                default: n = ST_0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/pattern_fsm_ch.sv
// One FSM channel: state register, Moore z decode, sticky error flag and,
// when PATTERN_FSM_HIT_CNT_EN is defined, a saturating hit counter.
module pattern_fsm_ch
    import pattern_fsm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             en_i,
    input  logic             x_i,
    input  logic             clr_i,
    output logic [2:0]       state_o,
    output logic             z_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic             err_o
);

    state_t state_q, state_d;
    logic   err_q, err_d;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = fsm_next(state_q, en_i, x_i);
    end

    always_comb begin
        z_o = (state_q == ST_3) || (state_q == ST_4);
    end

    // A fresh illegal detection wins over a coincident clear.
    always_comb begin
        err_d = state_illegal(state_q) | (err_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

`ifdef PATTERN_FSM_HIT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && z_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt_o = cnt_q;
`else
    assign hit_cnt_o = '0;
`endif

    assign state_o = state_q;
    assign err_o   = err_q;

endmodule

// File: rtl/pattern_fsm_bank.sv
// Bank of NUM_CH independent pattern FSM channels with packed outputs.
// Hit counters exist only when PATTERN_FSM_HIT_CNT_EN is defined.
module pattern_fsm_bank
    import pattern_fsm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       x,
    input  logic                    clr,
    output logic [3*NUM_CH-1:0]     state_o,
    output logic [NUM_CH-1:0]       z,
    output logic [CNT_W*NUM_CH-1:0] hit_cnt,
    output logic [NUM_CH-1:0]       err
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pattern_fsm_ch #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk      (clk),
                .aresetn  (aresetn),
                .en_i     (en[gi]),
                .x_i      (x[gi]),
                .clr_i    (clr),
                .state_o  (state_o[3*gi +: 3]),
                .z_o      (z[gi]),
                .hit_cnt_o(hit_cnt[CNT_W*gi +: CNT_W]),
                .err_o    (err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pattern_fsm_bank.sv
// Randomized bench for pattern_fsm_bank against a table-driven reference model.
// Counter expectations follow PATTERN_FSM_HIT_CNT_EN when it is defined.
module tb_pattern_fsm_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef PATTERN_FSM_HIT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    aresetn = 1'b0;
    logic [NUM_CH-1:0]       en = '0;
    logic [NUM_CH-1:0]       x = '0;
    logic                    clr = 1'b0;
    logic [3*NUM_CH-1:0]     state_o;
    logic [NUM_CH-1:0]       z;
    logic [CNT_W*NUM_CH-1:0] hit_cnt;
    logic [NUM_CH-1:0]       err;

    pattern_fsm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .aresetn(aresetn), .en(en), .x(x), .clr(clr),
        .state_o(state_o), .z(z), .hit_cnt(hit_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: state number, sticky error and hit count per channel.
    int m_st[NUM_CH];
    int m_err[NUM_CH];
    int m_cnt[NUM_CH];
    // Transition table indexed [x][state].
    int tbl[2][5] = '{'{0, 1, 2, 1, 3}, '{1, 4, 1, 2, 4}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_exp(input int v);
        return CNT_ON ? v : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_st[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] xv, input logic c);
        for (int i = 0; i < NUM_CH; i++) begin
            bit zi = (m_st[i] == 3) || (m_st[i] == 4);
            if (c) m_cnt[i] = 0;
            else if (e[i] && zi && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            if (m_st[i] > 4) begin
                m_st[i] = 0; m_err[i] = 1;
            end else begin
                if (c) m_err[i] = 0;
                if (e[i]) m_st[i] = tbl[xv[i]][m_st[i]];
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] es = 0, ez = 0, ec = 0, ee = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            es |= 32'(m_st[i]) << (3 * i);
            ez |= 32'((m_st[i] == 3) || (m_st[i] == 4)) << i;
            ec |= 32'(cnt_exp(m_cnt[i])) << (CNT_W * i);
            ee |= 32'(m_err[i]) << i;
        end
        check({tag, ".state"}, 32'(state_o), es);
        check({tag, ".z"}, 32'(z), ez);
        check({tag, ".cnt"}, 32'(hit_cnt), ec);
        check({tag, ".err"}, 32'(err), ee);
    endtask

    // Called just after a falling edge; applies inputs across one rising edge.
    task automatic step(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] xv, input logic c, input string tag);
        en = e; x = xv; clr = c;
        @(posedge clk);
        model_edge(e, xv, c);
        @(negedge clk);
        compare_all(tag);
        $display("[TB] %s en=%b x=%b clr=%b state=%h z=%b cnt=%h err=%b", tag, e, xv, c, state_o, z, hit_cnt, err);
    endtask

    task automatic deposit_ch2(input logic [2:0] v);
        force dut.g_ch[2].u_ch.state_q = v;
        #1;
        release dut.g_ch[2].u_ch.state_q;
        m_st[2] = int'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq_x   [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
        int         seq_st  [4] = '{1, 4, 3, 1};
        int         seq_z   [4] = '{0, 1, 1, 0};
        int         sat_cnt [5] = '{1, 2, 3, 3, 3};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        compare_all("init");

        for (int n = 0; n < 40; n++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0), "rnd1");
        end

        // Mid-cycle asynchronous reset from a known non-idle state.
        step(4'hf, 4'hf, 1'b0, "prerst");
        #2 aresetn = 1'b0;
        #1;
        check("rst.state", 32'(state_o), 32'd0);
        check("rst.z", 32'(z), 32'd0);
        check("rst.cnt", 32'(hit_cnt), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        model_reset();
        @(negedge clk);
        aresetn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            step(4'b0001, {3'($urandom), seq_x[k][0]}, 1'b0, "seq");
            check("seq.st0", 32'(state_o[2:0]), 32'(seq_st[k]));
            check("seq.z0", 32'(z[0]), 32'(seq_z[k]));
            check("seq.others", 32'(state_o[11:3]), 32'd0);
        end

        step(4'b0001, 4'b0001, 1'b0, "to100");
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 4'(k[0]), 1'b0, "hold");
            check("hold.st0", 32'(state_o[2:0]), 32'd4);
            check("hold.z0", 32'(z[0]), 32'd1);
            check("hold.cnt0", 32'(hit_cnt[1:0]), 32'(cnt_exp(2)));
        end

        step(4'b0000, 4'b0000, 1'b1, "clr");
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, 4'b0001, 1'b0, "sat");
            check("sat.cnt0", 32'(hit_cnt[1:0]), 32'(cnt_exp(sat_cnt[k])));
        end
        step(4'b0001, 4'b0001, 1'b1, "clrcoll");
        check("clrcoll.cnt0", 32'(hit_cnt[1:0]), 32'd0);

        deposit_ch2(3'b110);
        check("ill.dep", 32'(state_o[8:6]), 32'd6);
        step(4'($urandom), 4'($urandom), 1'b0, "ill");
        check("ill.st2", 32'(state_o[8:6]), 32'd0);
        check("ill.err2", 32'(err[2]), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step(4'($urandom), 4'($urandom), 1'b0, "sticky");
            check("sticky.err2", 32'(err[2]), 32'd1);
        end
        step(4'($urandom), 4'($urandom), 1'b1, "errclr");
        check("errclr.err2", 32'(err[2]), 32'd0);
        deposit_ch2(3'b111);
        step(4'($urandom), 4'($urandom), 1'b1, "illclr");
        check("illclr.err2", 32'(err[2]), 32'd1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 63) == 0) deposit_ch2(3'($urandom_range(5, 7)));
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0), "rnd2");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
